// File: rtl/uart_tx_queue_pkg.sv
// Shared types and constants for the UART transmit queue.
//   byte_t          one FIFO entry / serial character
//   BYTES_PER_WORD  bytes unpacked from one 32-bit word write
//   WORD_W          width of the write payload
package uart_tx_queue_pkg;

   typedef logic [7:0] byte_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/uart_tx_queue_unpack.sv
// Write-side unpacker: takes one byte or one 32-bit word per accepted write and feeds the
// FIFO one byte per cycle, MSB byte first.
//   CLK, RSTN        clock, synchronous active-low reset
//   wr_data/word/valid/ready  write port (wr_ready is low while RSTN is low)
//   push, push_data  one byte into the FIFO this cycle
//   full             FIFO full, from registered pointers
module uart_tx_queue_unpack
   import uart_tx_queue_pkg::*;
(
   input  logic              CLK,
   input  logic              RSTN,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_word,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              push,
   output byte_t             push_data,
   input  logic              full
);

   logic [WORD_W-1:0] r_sh;
   logic [2:0]        r_remaining;
   logic              w_accept;

   assign push      = (r_remaining != 3'd0) && !full;
   assign push_data = r_sh[WORD_W-1 -: 8];

   // Accept while empty, or while the last held byte leaves this very cycle.
   assign wr_ready = RSTN && ((r_remaining == 3'd0) || ((r_remaining == 3'd1) && !full));
   assign w_accept = wr_valid && wr_ready;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_sh        <= '0;
         r_remaining <= 3'd0;
      end else if (w_accept) begin
         // A coinciding final push has already taken the old r_sh[31:24].
         r_sh        <= wr_word ? wr_data : {wr_data[7:0], 24'h000000};
         r_remaining <= wr_word ? 3'(BYTES_PER_WORD) : 3'd1;
      end else if (push) begin
         r_sh        <= {r_sh[WORD_W-9:0], 8'h00};
         r_remaining <= r_remaining - 3'd1;
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of the UART sender. Accepts bytes or 32-bit words (unpacked MSB first)
// and presents bytes on a valid/ready port wired straight to the sender.
//   CLK, RSTN                     clock, synchronous active-low reset
//   wr_data, wr_word, wr_valid, wr_ready   write port
//   out_data, out_valid, out_ready         byte port to sender
//   count                         bytes held in the FIFO (unpacker contents excluded)
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [WORD_W-1:0]     wr_data,
   input  logic                  wr_word,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output byte_t                 out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   byte_t               r_mem [DEPTH];
   logic [DEPTH_LOG2:0] r_wr_ptr;
   logic [DEPTH_LOG2:0] r_rd_ptr;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   byte_t               w_push_data;

   uart_tx_queue_unpack u_unpack (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .wr_data   (wr_data),
      .wr_word   (wr_word),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .push      (w_push),
      .push_data (w_push_data),
      .full      (w_full)
   );

   // Pointers carry one extra wrap bit to tell full from empty.
   assign w_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   assign out_valid = RSTN && !w_empty;
   assign w_pop     = out_valid && out_ready;
   assign out_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
   assign count     = RSTN ? (r_wr_ptr - r_rd_ptr) : '0;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_push_data;
   end

endmodule
